// File: rtl/load_store_unit_pkg.sv
// Shared CPU definitions for the load/store unit: RISC-V width codes, FSM states
// and the access-legality helpers used when a request is accepted.
package load_store_unit_pkg;

    localparam logic [2:0] Funct3Byte  = 3'b000;
    localparam logic [2:0] Funct3Half  = 3'b001;
    localparam logic [2:0] Funct3Word  = 3'b010;
    localparam logic [2:0] Funct3ByteU = 3'b100;
    localparam logic [2:0] Funct3HalfU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StRmwRd,
        StRmwWr,
        StFin
    } lsu_state_e;

    function automatic logic lsu_illegal(input logic st, input logic [2:0] funct3);
        logic bad;
        case (funct3)
            Funct3Byte, Funct3Half, Funct3Word: bad = 1'b0;
            Funct3ByteU, Funct3HalfU:           bad = st;
            default:                            bad = 1'b1;
        endcase
        return bad;
    endfunction

    // size is funct3[1:0]: 01 halfword, 10 word, anything else needs no alignment
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            2'b01:   mis = offset[0];
            2'b10:   mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane logic: extracts and extends load data from a cache word, and
// merges sub-word store data into a previously read word.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rword[31:16] : rword[15:0];

        load_data = rword;
        case (funct3)
            Funct3Byte:  load_data = {{24{byte_sel[7]}}, byte_sel};
            Funct3Half:  load_data = {{16{half_sel[15]}}, half_sel};
            Funct3ByteU: load_data = {24'h0, byte_sel};
            Funct3HalfU: load_data = {16'h0, half_sel};
            default:     load_data = rword;
        endcase

        merged = rword;
        case (funct3)
            Funct3Byte: merged[{offset, 3'b000} +: 8] = wdata[7:0];
            Funct3Half: begin
                if (offset[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default:    merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core and a word-wide cache port; sub-word stores are
// done as read-modify-write, and every cache access is bounded by TIMEOUT wait cycles.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        st,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] caddr,
    output logic [31:0] cdin,
    output logic        cwe,
    output logic        crreq,
    input  logic [31:0] cdout,
    input  logic        crdy
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    lsu_state_e     state_q, state_d;
    logic           first_q, first_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    cdin_q, cdin_d;
    logic           err_q, err_d;

    logic [31:0]    load_data;
    logic [31:0]    merged;
    logic           in_access;
    logic           access_done;
    logic           timed_out;

    lsu_lane_align u_lane_align (
        .funct3    (funct3_q),
        .offset    (addr_q[1:0]),
        .rword     (cdout),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // CRDY seen in the strobe cycle belongs to no access of ours and is ignored
    assign in_access   = (state_q inside {StRd, StWr, StRmwRd, StRmwWr});
    assign access_done = !first_q && crdy;
    assign timed_out   = !first_q && !crdy && (cnt_q == CntMax);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cdin_d   = cdin_q;
        err_d    = err_q;

        if (in_access) begin
            if (first_q) begin
                cnt_d = '0;
            end else if (!crdy) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (req) begin
                    funct3_d = funct3;
                    addr_d   = addr;
                    wdata_d  = wdata;
                    err_d    = lsu_illegal(st, funct3) || lsu_misaligned(funct3[1:0], addr[1:0]);
                    if (err_d) begin
                        state_d = StFin;
                    end else if (!st) begin
                        state_d = StRd;
                    end else if (funct3 == Funct3Word) begin
                        state_d = StWr;
                        cdin_d  = wdata;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRd: begin
                if (access_done) begin
                    rdata_d = load_data;
                    state_d = StFin;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end
            end
            StRmwRd: begin
                if (access_done) begin
                    cdin_d  = merged;
                    state_d = StRmwWr;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end
            end
            StWr, StRmwWr: begin
                if (access_done) begin
                    state_d = StFin;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        first_d = (state_d != state_q) && (state_d inside {StRd, StWr, StRmwRd, StRmwWr});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            first_q  <= 1'b0;
            cnt_q    <= '0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            cdin_q   <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cdin_q   <= cdin_d;
            err_q    <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign busy  = (state_q != StIdle) && (state_q != StFin);
    assign done  = (state_q == StFin);
    assign err   = done && err_q;
    assign crreq = first_q && (state_q == StRd || state_q == StRmwRd);
    assign cwe   = first_q && (state_q == StWr || state_q == StRmwWr);
    assign caddr = {addr_q[31:2], 2'b00};
    assign cdin  = cdin_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-level reference model plus a latency-programmable
// cache responder, with a per-cycle output compare and directed literal checks.
module tb_load_store_unit;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst, req, st;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata, caddr, cdin;
    logic [31:0] cdout = 32'h0;
    logic        crdy = 1'b0;
    logic        busy, done, err, cwe, crreq;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .st     (st),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .caddr  (caddr),
        .cdin   (cdin),
        .cwe    (cwe),
        .crreq  (crreq),
        .cdout  (cdout),
        .crdy   (crdy)
    );

    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Cache responder: answers each strobe after rsp_lat extra cycles (negative = never)
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          rsp_lat = 0;
    bit          rsp_glitch = 0;
    bit          rsp_active = 0;
    bit          rsp_is_wr = 0;
    int          rsp_wait = 0;
    logic [31:0] rsp_addr = 32'h0;
    logic [31:0] rsp_wd = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    int          cr_n = 0;
    int          we_n = 0;

    always @(negedge clk) begin
        crdy = 1'b0;
        if (rst) begin
            rsp_active = 0;
        end else begin
            if (rsp_active) begin
                if (rsp_wait == 0) begin
                    crdy = 1'b1;
                    rsp_active = 0;
                    if (rsp_is_wr) begin
                        check("cdin_stable", cdin, rsp_wd);
                        mem[rsp_addr] = cdin;
                    end else begin
                        cdout = mem[rsp_addr];
                    end
                end else begin
                    rsp_wait--;
                end
            end
            if (crreq || cwe) begin
                if (crreq) cr_n++;
                if (cwe) begin
                    we_n++;
                    last_wr_data = cdin;
                end
                rsp_addr   = caddr;
                rsp_is_wr  = cwe;
                rsp_wd     = cdin;
                rsp_active = (rsp_lat >= 0);
                rsp_wait   = rsp_lat;
                if (rsp_glitch) begin
                    crdy  = 1'b1;
                    cdout = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Expected-behaviour state of the current transaction
    bit          chk_en = 0;
    bit          txn_active = 0;
    int          since = 0;
    int          exp_lat = 0;
    bit          exp_err = 0;
    logic [31:0] rdata_before = 32'h0;
    logic [31:0] rdata_after = 32'h0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("strobe_excl", 32'(crreq & cwe), 32'd0);
            if (txn_active) begin
                since++;
                check("done", 32'(done), 32'(since == exp_lat));
                check("busy", 32'(busy), 32'(since < exp_lat));
                check("err", 32'(err), 32'(since == exp_lat && exp_err));
                check("rdata", rdata, (since >= exp_lat) ? rdata_after : rdata_before);
                if (since >= exp_lat) begin
                    txn_active = 0;
                    rdata_before = rdata_after;
                end
            end else begin
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_done", 32'(done), 32'd0);
                check("idle_err", 32'(err), 32'd0);
                check("idle_strobe", 32'(crreq | cwe), 32'd0);
                check("idle_rdata", rdata, rdata_before);
            end
        end
    end

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] v;
        v = w >> (8 * int'(off));
        case (f3)
            3'd0:    v = {{24{v[7]}}, v[7:0]};
            3'd1:    v = {{16{v[15]}}, v[15:0]};
            3'd4:    v = {24'h0, v[7:0]};
            3'd5:    v = {16'h0, v[15:0]};
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic do_op(input string name, input bit s, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int lat,
                         input bit glitch, output int cycles);
        int          sz;
        bit          legal, e, rmw;
        int          e_cr, e_we, e_lat;
        logic [31:0] wa, w;
        sz    = size_of(f3);
        legal = s ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        e     = !legal || ((int'(a[1:0]) % sz) != 0);
        rmw   = s && sz < 4;
        wa    = {a[31:2], 2'b00};
        e_cr  = (!e && (!s || rmw)) ? 1 : 0;
        e_we  = (!e && s && (!rmw || lat >= 0)) ? 1 : 0;
        if (e)            e_lat = 1;
        else if (lat < 0) e_lat = TO + 2;
        else if (rmw)     e_lat = 2 * (lat + 2) + 1;
        else              e_lat = lat + 3;
        rdata_after = rdata_before;
        if (!e && lat >= 0) begin
            w = ref_mem[wa];
            if (!s) begin
                rdata_after = load_val(w, a[1:0], f3);
            end else begin
                for (int i = 0; i < sz; i++) w[(int'(a[1:0]) + i) * 8 +: 8] = wd[i * 8 +: 8];
                ref_mem[wa] = w;
            end
        end

        @(posedge clk);
        #1;
        rsp_lat = lat;
        rsp_glitch = glitch;
        cr_n = 0;
        we_n = 0;
        st = s;
        funct3 = f3;
        addr = a;
        wdata = wd;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        since = 0;
        exp_lat = e_lat;
        exp_err = e || lat < 0;
        txn_active = 1;
        cycles = 1;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        last_err = err;
        check({name, "_done_seen"}, 32'(done), 32'd1);
        check({name, "_latency"}, 32'(cycles), 32'(e_lat));
        if (!done) txn_active = 0;
        @(posedge clk);
        #1;
        check({name, "_crreq_n"}, 32'(cr_n), 32'(e_cr));
        check({name, "_cwe_n"}, 32'(we_n), 32'(e_we));
        if (s) check({name, "_mem"}, mem[wa], ref_mem[wa]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int c;

    initial begin
        rst = 1'b1;
        req = 1'b0;
        st = 1'b0;
        funct3 = 3'd0;
        addr = 32'h0;
        wdata = 32'h0;
        mem[32'h100] = 32'h80FF_1234;
        mem[32'h200] = 32'h1122_3344;
        mem[32'h204] = 32'h0;
        mem[32'h208] = 32'h0;
        mem[32'h300] = 32'h5566_7788;
        ref_mem = mem;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_outs", {26'h0, busy, done, err, cwe, crreq, 1'b0}, 32'h0);
        check("rst_caddr", caddr, 32'h0);
        check("rst_cdin", cdin, 32'h0);
        rst = 1'b0;
        chk_en = 1;

        do_op("lb_103", 0, 3'd0, 32'h103, 32'h0, 0, 0, c);
        check("lb_103_lit", rdata, 32'hFFFF_FF80);
        check("lb_103_err_lit", 32'(last_err), 32'd0);
        do_op("lbu_103", 0, 3'd4, 32'h103, 32'h0, 2, 0, c);
        check("lbu_103_lit", rdata, 32'h0000_0080);
        do_op("lh_102", 0, 3'd1, 32'h102, 32'h0, 1, 1, c);
        check("lh_102_lit", rdata, 32'hFFFF_80FF);
        do_op("lhu_100", 0, 3'd5, 32'h100, 32'h0, 0, 0, c);
        check("lhu_100_lit", rdata, 32'h0000_1234);
        do_op("lw_100", 0, 3'd2, 32'h100, 32'h0, 1, 1, c);
        check("lw_100_lit", rdata, 32'h80FF_1234);

        do_op("sh_202", 1, 3'd1, 32'h202, 32'h0000_BEEF, 0, 0, c);
        check("sh_202_cdin_lit", last_wr_data, 32'hBEEF_3344);
        check("sh_202_strobes_lit", 32'(cr_n * 16 + we_n), 32'h11);
        check("sh_202_rdata_kept", rdata, 32'h80FF_1234);
        do_op("lw_200", 0, 3'd2, 32'h200, 32'h0, 0, 0, c);
        check("lw_200_lit", rdata, 32'hBEEF_3344);
        do_op("sb_201", 1, 3'd0, 32'h201, 32'h1234_56A5, 1, 1, c);
        check("sb_201_mem_lit", mem[32'h200], 32'hBEEF_A544);
        do_op("sw_204", 1, 3'd2, 32'h204, 32'h1234_5678, 3, 0, c);
        do_op("lw_204", 0, 3'd2, 32'h204, 32'h0, 0, 0, c);
        check("lw_204_lit", rdata, 32'h1234_5678);

        do_op("lw_101", 0, 3'd2, 32'h101, 32'h0, 0, 0, c);
        check("lw_101_err_lit", 32'(last_err), 32'd1);
        check("lw_101_lat_lit", 32'(c), 32'd1);
        do_op("lh_103", 0, 3'd1, 32'h103, 32'h0, 0, 0, c);
        do_op("sh_201", 1, 3'd1, 32'h201, 32'hFFFF, 0, 0, c);
        do_op("f3_011", 0, 3'd3, 32'h100, 32'h0, 0, 0, c);
        do_op("f3_110", 0, 3'd6, 32'h100, 32'h0, 0, 0, c);
        do_op("st_f3_100", 1, 3'd4, 32'h100, 32'h0, 0, 0, c);
        check("illegal_rdata_kept", rdata, 32'h1234_5678);

        do_op("to_lw", 0, 3'd2, 32'h100, 32'h0, -1, 0, c);
        check("to_lw_lat_lit", 32'(c), 32'd10);
        check("to_lw_err_lit", 32'(last_err), 32'd1);
        do_op("to_sw", 1, 3'd2, 32'h208, 32'hCAFE_F00D, -1, 0, c);
        check("to_sw_mem_lit", mem[32'h208], 32'h0);

        // Reset while the read half of a byte store is outstanding
        @(posedge clk);
        #1;
        rsp_lat = -1;
        rsp_glitch = 0;
        cr_n = 0;
        we_n = 0;
        st = 1'b1;
        funct3 = 3'd0;
        addr = 32'h301;
        wdata = 32'h77;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk_en = 0;
        check("rmw_rd_strobe_lit", 32'(crreq), 32'd1);
        @(posedge clk);
        #1;
        check("rmw_rd_busy_lit", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_outs", {26'h0, busy, done, err, cwe, crreq, 1'b0}, 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_caddr", caddr, 32'h0);
        check("mid_rst_cdin", cdin, 32'h0);
        txn_active = 0;
        rdata_before = 32'h0;
        chk_en = 1;
        repeat (12) @(posedge clk);
        #1;
        check("mid_rst_no_cwe", 32'(we_n), 32'd0);
        check("mid_rst_mem", mem[32'h300], 32'h5566_7788);

        do_op("lb_100", 0, 3'd0, 32'h100, 32'h0, 0, 0, c);
        check("lb_100_lit", rdata, 32'h0000_0034);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
